// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants.
package riscv_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats drain, stall holds.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_VALUE = NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_flush,
  input  logic            i_load,
  input  logic            i_stall,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc_plus_4,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus_4,
  output logic            o_valid
);

  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus_4;
  logic            r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_instr     <= NOP_VALUE;
      r_pc        <= XLEN'(RESET_PC);
      r_pc_plus_4 <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_instr <= NOP_VALUE;
    end else if (i_load) begin
      r_valid     <= 1'b1;
      r_instr     <= i_instr;
      r_pc        <= i_pc;
      r_pc_plus_4 <= i_pc_plus_4;
    end else if (!i_stall) begin
      // Draining leaves the register empty, which decode must see as a NOP.
      r_valid <= 1'b0;
      r_instr <= NOP_VALUE;
    end
  end

  assign o_instr     = r_instr;
  assign o_pc        = r_pc;
  assign o_pc_plus_4 = r_pc_plus_4;
  assign o_valid     = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding req/gnt/rvalid transaction, skid buffer
// for responses that arrive while decode stalls, and PC advance gating.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus_4,
  output logic            pc_advance,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            stall_d,
  input  logic            flush_d,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus_4_d,
  output logic            valid_d
);

  fetch_state_t r_state;
  fetch_state_t w_next;

  logic            r_kill;
  logic [XLEN-1:0] r_tag_pc;
  logic [XLEN-1:0] r_tag_pc4;
  logic [31:0]     r_skid_instr;
  logic [XLEN-1:0] r_skid_pc;
  logic [XLEN-1:0] r_skid_pc4;

  logic            w_load;
  logic            w_sel_skid;
  logic            w_tag_en;
  logic            w_skid_en;
  logic            w_kill_set;
  logic            w_kill_clr;
  logic [31:0]     w_ld_instr;
  logic [XLEN-1:0] w_ld_pc;
  logic [XLEN-1:0] w_ld_pc4;

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_sel_skid = 1'b0;
    w_tag_en   = 1'b0;
    w_skid_en  = 1'b0;
    w_kill_set = 1'b0;
    w_kill_clr = 1'b0;
    case (r_state)
      IDLE: w_next = REQ;
      REQ: begin
        if (imem_gnt) begin
          w_next     = WAIT;
          w_tag_en   = 1'b1;
          w_kill_set = flush_d;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          w_next = REQ;
          // A killed or redirected response is dropped without advancing.
          if (r_kill) begin
            w_kill_clr = 1'b1;
          end else if (!flush_d) begin
            if (!valid_d || !stall_d) begin
              w_load = 1'b1;
            end else begin
              w_skid_en = 1'b1;
              w_next    = HOLD;
            end
          end
        end else if (flush_d) begin
          w_kill_set = 1'b1;
        end
      end
      HOLD: begin
        if (flush_d) begin
          w_next = REQ;
        end else if (!stall_d) begin
          w_load     = 1'b1;
          w_sel_skid = 1'b1;
          w_next     = REQ;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_kill       <= 1'b0;
      r_tag_pc     <= '0;
      r_tag_pc4    <= '0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_pc4   <= '0;
    end else begin
      r_state <= w_next;
      if (w_kill_set) begin
        r_kill <= 1'b1;
      end else if (w_kill_clr) begin
        r_kill <= 1'b0;
      end
      if (w_tag_en) begin
        r_tag_pc  <= pc;
        r_tag_pc4 <= pc_plus_4;
      end
      if (w_skid_en) begin
        r_skid_instr <= imem_rdata;
        r_skid_pc    <= r_tag_pc;
        r_skid_pc4   <= r_tag_pc4;
      end
    end
  end

  assign w_ld_instr = w_sel_skid ? r_skid_instr : imem_rdata;
  assign w_ld_pc    = w_sel_skid ? r_skid_pc    : r_tag_pc;
  assign w_ld_pc4   = w_sel_skid ? r_skid_pc4   : r_tag_pc4;

  assign imem_req   = (r_state == REQ);
  assign imem_addr  = pc;
  assign pc_advance = w_load | flush_d;

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_VALUE (NOP_INSTR)
  ) u_if_id (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (flush_d),
    .i_load      (w_load),
    .i_stall     (stall_d),
    .i_instr     (w_ld_instr),
    .i_pc        (w_ld_pc),
    .i_pc_plus_4 (w_ld_pc4),
    .o_instr     (instr_d),
    .o_pc        (pc_d),
    .o_pc_plus_4 (pc_plus_4_d),
    .o_valid     (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: bench-side PC and variable-latency memory, a
// transaction-level reference model checked every cycle, plus directed cases.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] pc_plus_4;
  logic        pc_advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall_d = 1'b0;
  logic        flush_d = 1'b0;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus_4_d;
  logic        valid_d;

  assign pc_plus_4 = pc + 32'd4;

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN      (32),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_plus_4   (pc_plus_4),
    .pc_advance  (pc_advance),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus_4_d (pc_plus_4_d),
    .valid_d     (valid_d)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_adv   = 0;

  function automatic void chk32(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk1(string nm, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] memw(logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  // Memory / PC environment knobs and state
  int          lat_min = 1;
  int          lat_max = 1;
  int          gnt_pct = 100;
  logic        mbusy = 1'b0;
  int          mcnt = 0;
  logic [31:0] maddr = '0;
  logic [31:0] tgt = '0;

  // Values sampled on the falling edge for the environment's next cycle
  logic        s_reset = 1'b1;
  logic        s_adv = 1'b0;
  logic        s_flush = 1'b0;
  logic        s_granted = 1'b0;
  logic [31:0] s_tgt = '0;
  logic [31:0] s_gaddr = '0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (s_reset) pc = '0;
    else if (s_adv) pc = s_flush ? s_tgt : pc + 32'd4;
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    imem_rdata  = $urandom;
    if (s_reset) begin
      mbusy = 1'b0;
    end else begin
      if (s_granted) begin
        mbusy = 1'b1;
        maddr = s_gaddr;
        mcnt  = int'($urandom_range(lat_max, lat_min));
      end
      if (mbusy) begin
        mcnt--;
        if (mcnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memw(maddr);
          mbusy       = 1'b0;
        end
      end
    end
    if (imem_req && !mbusy && int'($urandom_range(99)) < gnt_pct) imem_gnt = 1'b1;
  endtask

  // Reference model: one outstanding fetch, one parked response, IF/ID contents
  logic        m_valid = 1'b0;
  logic [31:0] m_pcd = '0;
  logic [31:0] m_pc4 = '0;
  logic [31:0] m_instr = NOP;
  logic        m_out = 1'b0;
  logic        m_live = 1'b0;
  logic [31:0] m_addr = '0;
  logic        m_pend = 1'b0;
  logic [31:0] m_ppc = '0;
  logic        m_go_req = 1'b0;
  logic        m_idle = 1'b1;

  logic        c_arrive, c_live_arr, c_have, c_room, c_acc, c_resolved, c_go_n;
  logic [31:0] c_spc;

  always @(negedge clk) begin
    s_reset   = reset;
    s_adv     = pc_advance;
    s_flush   = flush_d;
    s_tgt     = tgt;
    s_granted = imem_req && imem_gnt && !reset;
    s_gaddr   = imem_addr;

    chk1 ("valid_d",     valid_d,     m_valid);
    chk32("pc_d",        pc_d,        m_pcd);
    chk32("pc_plus_4_d", pc_plus_4_d, m_pc4);
    chk32("instr_d",     instr_d,     m_instr);

    if (reset) begin
      m_valid  = 1'b0;
      m_pcd    = '0;
      m_pc4    = '0;
      m_instr  = NOP;
      m_out    = 1'b0;
      m_live   = 1'b0;
      m_pend   = 1'b0;
      m_go_req = 1'b0;
      m_idle   = 1'b1;
    end else begin
      if (pc_advance) n_adv++;
      c_arrive   = imem_rvalid && m_out;
      c_live_arr = c_arrive && m_live && !flush_d;
      c_have     = m_pend || c_live_arr;
      c_spc      = m_pend ? m_ppc : m_addr;
      c_room     = !m_valid || !stall_d;
      c_acc      = c_have && c_room && !flush_d;

      chk1("imem_req", imem_req, m_go_req);
      if (imem_req) chk32("imem_addr", imem_addr, pc);
      chk1("pc_advance", pc_advance, c_acc || flush_d);

      c_resolved = (c_arrive && !(c_live_arr && !c_acc)) || (m_pend && (c_acc || flush_d));
      c_go_n     = m_idle || (m_go_req && !imem_gnt) || c_resolved;
      m_idle     = 1'b0;

      if (m_go_req && imem_gnt) begin
        m_out  = 1'b1;
        m_addr = pc;
        m_live = !flush_d;
      end else if (c_arrive) begin
        m_out = 1'b0;
      end else if (m_out && flush_d) begin
        m_live = 1'b0;
      end

      if (c_live_arr && !c_acc) begin
        m_pend = 1'b1;
        m_ppc  = m_addr;
      end else if (m_pend && (c_acc || flush_d)) begin
        m_pend = 1'b0;
      end

      if (flush_d) begin
        m_valid = 1'b0;
        m_instr = NOP;
      end else if (c_acc) begin
        m_valid = 1'b1;
        m_pcd   = c_spc;
        m_pc4   = c_spc + 32'd4;
        m_instr = memw(c_spc);
      end else if (!stall_d) begin
        m_valid = 1'b0;
        m_instr = NOP;
      end
      m_go_req = c_go_n;
    end
  end

  task automatic do_reset();
    reset   = 1'b1;
    stall_d = 1'b0;
    flush_d = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string nm, output int k);
    k = 0;
    while (!valid_d && k < 100) begin
      tick();
      k++;
    end
    chk1({nm, "_timeout"}, valid_d, 1'b1);
  endtask

  task automatic wait_gnt(input string nm, input logic [31:0] at_pc);
    int k;
    k = 0;
    while (!(imem_gnt && pc == at_pc) && k < 100) begin
      tick();
      k++;
    end
    chk1({nm, "_gnt_timeout"}, imem_gnt, 1'b1);
  endtask

  initial begin
    int k;
    int n0;
    logic [31:0] q[$];
    logic [31:0] exp2 [4];

    // T1: zero-wait memory, first instruction three cycles after reset release
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    do_reset();
    n0 = n_adv;
    wait_valid("t1", k);
    chk32("t1_first_valid_cycle", k, 3);
    chk32("t1_pc_d", pc_d, 32'h0);
    chk32("t1_pc4_d", pc_plus_4_d, 32'h4);
    chk32("t1_instr", instr_d, 32'hA500_0000);
    chk32("t1_adv_count", n_adv - n0, 1);

    // T2: 3-cycle latency, four sequential fetches
    lat_min = 3; lat_max = 3;
    do_reset();
    n0 = n_adv;
    exp2 = '{32'h0, 32'h4, 32'h8, 32'hC};
    q.delete();
    k = 0;
    while (q.size() < 4 && k < 100) begin
      tick();
      k++;
      if (valid_d) q.push_back(pc_d);
    end
    chk32("t2_count", q.size(), 4);
    for (int i = 0; i < q.size() && i < 4; i++) chk32("t2_pc_seq", q[i], exp2[i]);
    chk32("t2_adv_count", n_adv - n0, 4);

    // T3: stall while the response arrives, then release
    lat_min = 1; lat_max = 1;
    do_reset();
    wait_valid("t3", k);
    stall_d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1 ("t3_stall_adv", pc_advance, 1'b0);
      chk32("t3_stall_pc_d", pc_d, 32'h0);
      chk1 ("t3_stall_valid", valid_d, 1'b1);
      tick();
    end
    stall_d = 1'b0;
    #1;
    chk1("t3_release_adv", pc_advance, 1'b1);
    tick();
    chk1 ("t3_skid_valid", valid_d, 1'b1);
    chk32("t3_skid_pc", pc_d, 32'h4);
    chk32("t3_skid_instr", instr_d, 32'hA500_0004);

    // T4: flush while waiting on the 0x10 response, redirect to 0x40
    lat_min = 3; lat_max = 3;
    do_reset();
    wait_gnt("t4", 32'h10);
    tick();
    flush_d = 1'b1;
    tgt     = 32'h40;
    tick();
    flush_d = 1'b0;
    chk1("t4_valid_after_flush", valid_d, 1'b0);
    wait_valid("t4", k);
    chk32("t4_pc_d", pc_d, 32'h40);
    chk32("t4_instr", instr_d, 32'hA500_0040);

    // T5a: flush coincident with rvalid
    lat_min = 1; lat_max = 1;
    do_reset();
    wait_gnt("t5a", 32'h0);
    tick();
    flush_d = 1'b1;
    tgt     = 32'h80;
    tick();
    flush_d = 1'b0;
    chk1("t5a_valid_after_flush", valid_d, 1'b0);
    wait_valid("t5a", k);
    chk32("t5a_pc_d", pc_d, 32'h80);
    chk32("t5a_instr", instr_d, 32'hA500_0080);

    // T5b: flush while the response is parked in the skid buffer
    stall_d = 1'b1;
    tick();
    tick();
    flush_d = 1'b1;
    tgt     = 32'hC0;
    tick();
    flush_d = 1'b0;
    chk1("t5b_valid_after_flush", valid_d, 1'b0);
    stall_d = 1'b0;
    wait_valid("t5b", k);
    chk32("t5b_pc_d", pc_d, 32'hC0);
    chk32("t5b_instr", instr_d, 32'hA500_00C0);

    // T6: reset during WAIT with a live instruction held in IF/ID
    lat_min = 3; lat_max = 3;
    do_reset();
    wait_gnt("t6", 32'h4);
    stall_d = 1'b1;
    tick();
    reset   = 1'b1;
    stall_d = 1'b0;
    tick();
    #1;
    chk1 ("t6_valid", valid_d, 1'b0);
    chk32("t6_instr", instr_d, 32'h0000_0013);
    chk32("t6_pc_d", pc_d, 32'h0);
    chk32("t6_pc4_d", pc_plus_4_d, 32'h0);
    chk1 ("t6_req", imem_req, 1'b0);
    chk1 ("t6_adv", pc_advance, 1'b0);
    reset = 1'b0;
    wait_valid("t6", k);
    chk32("t6_restart_pc", pc_d, 32'h0);
    chk32("t6_restart_instr", instr_d, 32'hA500_0000);

    // Randomized traffic: variable grant/latency, stalls, flushes, resets
    lat_min = 1; lat_max = 4; gnt_pct = 60;
    do_reset();
    n0 = n_adv;
    for (int i = 0; i < 4000; i++) begin
      tick();
      stall_d = ($urandom_range(99) < 35);
      flush_d = ($urandom_range(99) < 4);
      if (flush_d) tgt = $urandom_range(1023);
      reset = ($urandom_range(999) < 3);
    end
    reset   = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    repeat (4) tick();
    chk1("rand_progress", (n_adv - n0) > 200, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch controller directly downstream of program_counter. It consumes pc / pc_plus_4, issues one word request at a time to an instruction memory with a variable-latency req/gnt/rvalid interface, and loads the IF/ID pipeline register. It returns pc_advance to the program counter, gating its update so the PC moves only when the fetched instruction is accepted or the pipeline is redirected. Decode stall and flush are honoured.

Parameters:
XLEN, 32, datapath/address width
NOP_INSTR, 32'h0000_0013, value driven on instr_d when the IF/ID register is empty (addi x0,x0,0)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
pc  in  XLEN  current PC from program_counter
pc_plus_4  in  XLEN  pc+4 from program_counter
pc_advance  out  1  PC update enable (one-cycle pulse per advance)
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address (= pc while imem_req)
imem_gnt  in  1  memory accepted request this cycle
imem_rvalid  in  1  read data valid (>=1 cycle after gnt)
imem_rdata  in  32  instruction word
stall_d  in  1  decode cannot accept; hold IF/ID
flush_d  in  1  redirect; kill in-flight and IF/ID contents
instr_d  out  32  IF/ID instruction
pc_d  out  XLEN  IF/ID pc
pc_plus_4_d  out  XLEN  IF/ID pc+4
valid_d  out  1  IF/ID holds a live instruction

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values: state=IDLE, imem_req=0, pc_advance=0, valid_d=0, instr_d=NOP_INSTR, pc_d=0, pc_plus_4_d=0, kill=0, skid empty.
- Reset mid-operation: reset aborts any outstanding request. The memory is reset on the same reset, so no stale rvalid follows.
- FSM states:
  - IDLE: -> REQ on the next cycle.
  - REQ: imem_req=1, imem_addr=pc. On gnt, latch pc/pc_plus_4 into the request tag and -> WAIT.
  - WAIT: imem_req=0. On rvalid, if IF/ID is free or draining (!valid_d || !stall_d), load IF/ID, pulse pc_advance, and -> REQ. Otherwise capture the word and tag into the skid buffer and -> HOLD.
  - HOLD: on !stall_d, move the skid buffer into IF/ID, pulse pc_advance, and -> REQ.
- Single outstanding request only. Best case is one instruction per 2 cycles: gnt in the REQ cycle, rvalid in the next cycle, valid_d high the cycle after rvalid.
- pc_advance is combinational: (accept into IF/ID) OR flush_d. During flush the PC loads pc_target because pc_src is asserted by the redirecting stage in the same cycle.
- IF/ID register priority: flush_d -> valid_d<=0, instr_d<=NOP_INSTR. Else, if load -> valid_d<=1 with new word and tag. Else, if !stall_d -> valid_d<=0. Else hold all fields.
- Flush in REQ: if gnt is asserted in the same cycle, set kill and go to WAIT. The response is discarded on arrival, pc_advance is not pulsed, and the FSM goes to REQ.
- Flush in WAIT: set kill. The next rvalid is dropped.
- Flush in HOLD: drop the skid buffer and go to REQ.
- Flush coincident with rvalid: drop the data and go to REQ.
- Flush coincident with HOLD drain: flush wins and the skid contents are lost.
- kill clears when the dropped response is received.
- A frozen PC (halt address) simply refetches the same word. No special case.
- If pc[1:0]!=0 in REQ, the request is still issued. Alignment checking belongs to the branch unit.

Decomposition:
- riscv_pkg: fetch_state_t enum {IDLE, REQ, WAIT, HOLD}, NOP_INSTR constant, RESET_PC constant.
- Sub-module if_id_reg holds instr/pc/pc_plus_4/valid with load/hold/flush priority. The FSM and skid buffer stay in fetch_stage.

Test Plan:
- Reset, zero-wait memory (gnt immediate, rvalid next cycle), pc=0 -> imem_addr=0. valid_d rises with instr_d=mem[0] and pc_d=0 three cycles after reset deasserts. One pc_advance pulse per instruction.
- Memory with 3-cycle rvalid latency, 4 sequential fetches -> pc_d sequence 0,4,8,0xC. No duplicate or missing pc_advance.
- stall_d held for 4 cycles while rvalid arrives -> state HOLD, IF/ID unchanged, pc_advance=0. After release, the skid word appears next cycle and pc_advance pulses once.
- flush_d during WAIT for pc=0x10 -> the 0x10 response is dropped, valid_d=0. The next request uses the redirected pc (e.g. 0x40) and pc_d=0x40 is delivered.
- flush_d in the same cycle as rvalid, and flush_d in HOLD -> no stale instruction reaches valid_d=1, and the FSM returns to REQ.
- reset asserted in WAIT -> all outputs return to reset values next cycle, instr_d=0x00000013, and fetching restarts at pc=0.
